// File: rtl/line_fill_pkg.sv
// Shared cache line-fill definitions: FSM states, line geometry and
// address field positions common to the instruction and data caches.
package line_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } fill_state_e;

    localparam int LINE_WORDS = 4;
    localparam int WORD_W     = 32;
    localparam int TAG_W      = 20;
    localparam int INDEX_W    = 8;
    localparam int WSEL_W     = 2;

    // Byte address layout: tag[31:12], index[11:4], word[3:2], byte[1:0].
    localparam int TAG_LSB    = 12;
    localparam int INDEX_LSB  = 4;
    localparam int WORD_LSB   = 2;

    // Clears the byte offset so a burst always starts on a word boundary.
    localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

    // Line word written by beat k of a wrapping burst that starts at 'start'.
    function automatic logic [WSEL_W-1:0] wrap_word(input logic [WSEL_W-1:0] start,
                                                    input logic [WSEL_W-1:0] beat);
        return start + beat;
    endfunction

endpackage

// File: rtl/line_fill.sv
// Critical-word-first cache line filler: issues one wrapping 4-beat burst
// per miss, forwards the critical word early, then writes the whole line.
module line_fill
    import line_fill_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic         CLK,
    input  logic         nRESET,
    input  logic         REQ_VALID,
    output logic         REQ_READY,
    input  logic [31:0]  REQ_ADDR,
    output logic         MEM_REQ,
    output logic [31:0]  MEM_ADDR,
    input  logic         MEM_ACK,
    input  logic         MEM_RVALID,
    input  logic [31:0]  MEM_RDATA,
    input  logic         MEM_ERR,
    output logic         CRIT_VALID,
    output logic [31:0]  CRIT_DATA,
    output logic         FILL_VALID,
    output logic [19:0]  FILL_TAG,
    output logic [7:0]   FILL_INDEX,
    output logic [127:0] FILL_DATA,
    output logic         FILL_ERR
);

    // Idle cycles are counted 0..TIMEOUT-1; the abort fires on the last one.
    localparam int              TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    fill_state_e                          state_q, state_d;
    logic [31:0]                          addr_q, addr_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0]    line_q, line_d;
    logic [WSEL_W-1:0]                    cnt_q, cnt_d;
    logic                                 done_q, done_d;
    logic                                 err_q, err_d;
    logic [TMO_W-1:0]                     tmo_q, tmo_d;
    logic                                 crit_valid_q, crit_valid_d;
    logic [WORD_W-1:0]                    crit_data_q, crit_data_d;

    // Next-state and datapath update for the fill sequence.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        addr_d       = addr_q;
        line_d       = line_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        err_d        = err_q;
        tmo_d        = tmo_q;
        crit_valid_d = 1'b0;
        crit_data_d  = crit_data_q;

        unique case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    addr_d  = REQ_ADDR;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                // Beats are not expected before the address is accepted; any
                // MEM_RVALID seen here, even alongside MEM_ACK, is dropped.
                if (MEM_ACK) begin
                    tmo_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (MEM_RVALID && !done_q) begin
                    line_d[wrap_word(addr_q[WORD_LSB +: WSEL_W], cnt_q)] = MEM_RDATA;
                    tmo_d = '0;
                    if (MEM_ERR) begin
                        err_d = 1'b1;
                    end else if (cnt_q == '0) begin
                        crit_valid_d = 1'b1;
                        crit_data_d  = MEM_RDATA;
                    end
                    if (cnt_q == WSEL_W'(LINE_WORDS - 1)) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            // NOTE: the line buffer is reset because FILL_DATA must read zero out of reset; it is only four words.
            line_q       <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
            crit_valid_q <= crit_valid_d;
            crit_data_q  <= crit_data_d;
        end
    end

    assign REQ_READY  = (state_q == IDLE);
    assign MEM_REQ    = (state_q == ADDR);
    assign MEM_ADDR   = addr_q & WORD_ADDR_MASK;
    assign CRIT_VALID = crit_valid_q;
    assign CRIT_DATA  = crit_data_q;
    assign FILL_VALID = (state_q == DONE);
    assign FILL_ERR   = FILL_VALID & err_q;
    assign FILL_TAG   = addr_q[TAG_LSB +: TAG_W];
    assign FILL_INDEX = addr_q[INDEX_LSB +: INDEX_W];
    assign FILL_DATA  = line_q;

endmodule

// File: tb/tb_line_fill.sv
// Directed self-checking bench for line_fill: wrap order, delayed ack,
// bus errors, timeout abort and mid-burst reset.
module tb_line_fill;

    logic         CLK;
    logic         nRESET;
    logic         REQ_VALID;
    logic         REQ_READY;
    logic [31:0]  REQ_ADDR;
    logic         MEM_REQ;
    logic [31:0]  MEM_ADDR;
    logic         MEM_ACK;
    logic         MEM_RVALID;
    logic [31:0]  MEM_RDATA;
    logic         MEM_ERR;
    logic         CRIT_VALID;
    logic [31:0]  CRIT_DATA;
    logic         FILL_VALID;
    logic [19:0]  FILL_TAG;
    logic [7:0]   FILL_INDEX;
    logic [127:0] FILL_DATA;
    logic         FILL_ERR;

    int n_checks = 0;
    int n_errors = 0;

    line_fill #(.TIMEOUT(8)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .REQ_VALID  (REQ_VALID),
        .REQ_READY  (REQ_READY),
        .REQ_ADDR   (REQ_ADDR),
        .MEM_REQ    (MEM_REQ),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_ACK    (MEM_ACK),
        .MEM_RVALID (MEM_RVALID),
        .MEM_RDATA  (MEM_RDATA),
        .MEM_ERR    (MEM_ERR),
        .CRIT_VALID (CRIT_VALID),
        .CRIT_DATA  (CRIT_DATA),
        .FILL_VALID (FILL_VALID),
        .FILL_TAG   (FILL_TAG),
        .FILL_INDEX (FILL_INDEX),
        .FILL_DATA  (FILL_DATA),
        .FILL_ERR   (FILL_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic request(input logic [31:0] addr);
        REQ_VALID = 1'b1;
        REQ_ADDR  = addr;
        step();
        REQ_VALID = 1'b0;
    endtask

    task automatic ack();
        MEM_ACK = 1'b1;
        step();
        MEM_ACK = 1'b0;
    endtask

    task automatic beat(input logic [31:0] data, input logic err);
        MEM_RVALID = 1'b1;
        MEM_RDATA  = data;
        MEM_ERR    = err;
        step();
        MEM_RVALID = 1'b0;
        MEM_ERR    = 1'b0;
    endtask

    initial begin
        nRESET     = 1'b0;
        REQ_VALID  = 1'b0;
        REQ_ADDR   = '0;
        MEM_ACK    = 1'b0;
        MEM_RVALID = 1'b0;
        MEM_RDATA  = '0;
        MEM_ERR    = 1'b0;
        step();
        step();

        // Reset state.
        check("rst_req_ready",  REQ_READY,  1'b1);
        check("rst_mem_req",    MEM_REQ,    1'b0);
        check("rst_mem_addr",   MEM_ADDR,   32'h0);
        check("rst_crit_valid", CRIT_VALID, 1'b0);
        check("rst_crit_data",  CRIT_DATA,  32'h0);
        check("rst_fill_valid", FILL_VALID, 1'b0);
        check("rst_fill_err",   FILL_ERR,   1'b0);
        check("rst_fill_data",  FILL_DATA,  128'h0);
        nRESET = 1'b1;
        step();

        // Basic fill starting at word 2: beats land in words 2,3,0,1.
        request(32'h1234_5678);
        check("t1_mem_req",   MEM_REQ,   1'b1);
        check("t1_mem_addr",  MEM_ADDR,  32'h1234_5678);
        check("t1_req_ready", REQ_READY, 1'b0);
        ack();
        check("t1_mem_req_drop", MEM_REQ, 1'b0);
        beat(32'hAAAA_AAAA, 1'b0);
        check("t1_crit_valid", CRIT_VALID, 1'b1);
        check("t1_crit_data",  CRIT_DATA,  32'hAAAA_AAAA);
        beat(32'hBBBB_BBBB, 1'b0);
        check("t1_crit_pulse", CRIT_VALID, 1'b0);
        beat(32'hCCCC_CCCC, 1'b0);
        check("t1_no_fill_early", FILL_VALID, 1'b0);
        beat(32'hDDDD_DDDD, 1'b0);
        check("t1_fill_valid", FILL_VALID, 1'b1);
        check("t1_fill_err",   FILL_ERR,   1'b0);
        check("t1_fill_tag",   FILL_TAG,   20'h12345);
        check("t1_fill_index", FILL_INDEX, 8'h67);
        check("t1_fill_data",  FILL_DATA,  128'hBBBB_BBBB_AAAA_AAAA_DDDD_DDDD_CCCC_CCCC);
        step();
        check("t1_fill_pulse", FILL_VALID, 1'b0);
        check("t1_idle_ready", REQ_READY,  1'b1);
        check("t1_data_hold",  FILL_DATA,  128'hBBBB_BBBB_AAAA_AAAA_DDDD_DDDD_CCCC_CCCC);
        check("t1_tag_hold",   FILL_TAG,   20'h12345);

        // Delayed ack with stray beats in ADDR, then ack coincident with a beat.
        request(32'h0000_0A04);
        MEM_RVALID = 1'b1;
        MEM_RDATA  = 32'hDEAD_DEAD;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_req",  MEM_REQ,    1'b1);
            check("t2_hold_addr", MEM_ADDR,   32'h0000_0A04);
            check("t2_no_crit",   CRIT_VALID, 1'b0);
            step();
        end
        MEM_RDATA = 32'h0000_0BAD;
        ack();
        MEM_RVALID = 1'b0;
        check("t2_no_crit_on_ack", CRIT_VALID, 1'b0);
        beat(32'h0000_0011, 1'b0);
        check("t2_crit_valid", CRIT_VALID, 1'b1);
        check("t2_crit_data",  CRIT_DATA,  32'h0000_0011);
        beat(32'h0000_0022, 1'b0);
        beat(32'h0000_0033, 1'b0);
        beat(32'h0000_0044, 1'b0);
        check("t2_fill_valid", FILL_VALID, 1'b1);
        check("t2_fill_index", FILL_INDEX, 8'hA0);
        check("t2_fill_data",  FILL_DATA,  128'h0000_0033_0000_0022_0000_0011_0000_0044);
        step();

        // Error on the third beat; a request while busy must be ignored.
        request(32'h0000_0000);
        ack();
        beat(32'h1, 1'b0);
        check("t3_crit_valid", CRIT_VALID, 1'b1);
        REQ_VALID = 1'b1;
        REQ_ADDR  = 32'hFFFF_FFF0;
        beat(32'h2, 1'b0);
        check("t3_busy_ready", REQ_READY, 1'b0);
        beat(32'h3, 1'b1);
        REQ_VALID = 1'b0;
        beat(32'h4, 1'b0);
        check("t3_fill_valid", FILL_VALID, 1'b1);
        check("t3_fill_err",   FILL_ERR,   1'b1);
        check("t3_fill_tag",   FILL_TAG,   20'h00000);
        step();

        // Error on the critical beat suppresses CRIT_VALID.
        request(32'h0000_000C);
        ack();
        beat(32'h5, 1'b1);
        check("t4_crit_suppressed", CRIT_VALID, 1'b0);
        beat(32'h6, 1'b0);
        beat(32'h7, 1'b0);
        beat(32'h8, 1'b0);
        check("t4_fill_valid", FILL_VALID, 1'b1);
        check("t4_fill_err",   FILL_ERR,   1'b1);
        step();

        // Timeout: two beats then silence; abort 8 cycles after the last beat.
        request(32'h0000_0010);
        ack();
        beat(32'h9, 1'b0);
        beat(32'hA, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("t5_waiting", FILL_VALID, 1'b0);
        end
        step();
        check("t5_fill_valid", FILL_VALID, 1'b1);
        check("t5_fill_err",   FILL_ERR,   1'b1);
        step();
        check("t5_idle", REQ_READY, 1'b1);
        beat(32'hE, 1'b0);
        check("t5_stray_ignored", REQ_READY,  1'b1);
        check("t5_stray_no_crit", CRIT_VALID, 1'b0);

        // Reset after the first beat, then a clean fill.
        request(32'hFFFF_F00C);
        ack();
        beat(32'h5555_5555, 1'b0);
        check("t6_crit_before_rst", CRIT_VALID, 1'b1);
        nRESET = 1'b0;
        #1;
        check("t6_rst_ready",      REQ_READY,  1'b1);
        check("t6_rst_mem_req",    MEM_REQ,    1'b0);
        check("t6_rst_mem_addr",   MEM_ADDR,   32'h0);
        check("t6_rst_crit_valid", CRIT_VALID, 1'b0);
        check("t6_rst_crit_data",  CRIT_DATA,  32'h0);
        check("t6_rst_fill_data",  FILL_DATA,  128'h0);
        check("t6_rst_fill_tag",   FILL_TAG,   20'h0);
        #1;
        nRESET = 1'b1;
        beat(32'h6666_6666, 1'b0);
        beat(32'h7777_7777, 1'b0);
        check("t6_stray_no_fill", FILL_VALID, 1'b0);
        check("t6_stray_no_crit", CRIT_VALID, 1'b0);
        request(32'hABCD_E524);
        check("t6_mem_addr", MEM_ADDR, 32'hABCD_E524);
        ack();
        beat(32'hA0A0_A0A0, 1'b0);
        check("t6_crit_data", CRIT_DATA, 32'hA0A0_A0A0);
        beat(32'hB1B1_B1B1, 1'b0);
        beat(32'hC2C2_C2C2, 1'b0);
        beat(32'hD3D3_D3D3, 1'b0);
        check("t6_fill_valid", FILL_VALID, 1'b1);
        check("t6_fill_err",   FILL_ERR,   1'b0);
        check("t6_fill_tag",   FILL_TAG,   20'hABCDE);
        check("t6_fill_index", FILL_INDEX, 8'h52);
        check("t6_fill_data",  FILL_DATA,  128'hC2C2_C2C2_B1B1_B1B1_A0A0_A0A0_D3D3_D3D3);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
